// File: rtl/updown_counter.sv
// Programmable up/down event counter with run-time step, load, compare limit and
// wrap / saturate / one-shot policies. Optional sticky flags: COUNTER_STICKY_FLAGS_EN.
module updown_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count_val,
    output logic              overflow,
    output logic              underflow,
    output logic              match,
    output logic              done,
    output logic              sticky_ovf,
    output logic              sticky_unf
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SAT = 2'b01;
    localparam logic [1:0] MODE_ONE = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] next_s;
    logic             flow_s;
    logic             oneshot_hit_s;

    // Candidate next count and carry/borrow, computed in WIDTH+1 bits
    always_comb begin
        step_ext_s = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
        sum_s      = {1'b0, count_q} + step_ext_s;
        if (dir) begin
            next_s = count_q - step_ext_s[WIDTH-1:0];
            flow_s = (step_ext_s > {1'b0, count_q});
        end else begin
            next_s = sum_s[WIDTH-1:0];
            flow_s = sum_s[WIDTH];
        end
        if (dir) begin
            oneshot_hit_s = flow_s || (next_s <= limit);
        end else begin
            oneshot_hit_s = flow_s || (next_s >= limit);
        end
    end

    // Next-state logic: clear > load > enabled count step
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (clear) begin
            count_d = '0;
            state_d = ST_RUN;
        end else if (load) begin
            count_d = load_val;
            state_d = ST_RUN;
        end else if (en && (state_q == ST_RUN) && (step != '0)) begin
            case (mode)
                MODE_SAT: begin
                    if (flow_s) begin
                        count_d = dir ? '0 : '1;
                    end else begin
                        count_d = next_s;
                    end
                    ovf_d = flow_s & ~dir;
                    unf_d = flow_s & dir;
                end
                MODE_ONE: begin
                    if (oneshot_hit_s) begin
                        count_d = limit;
                        state_d = ST_HALT;
                    end else begin
                        count_d = next_s;
                    end
                end
                default: begin
                    // wrap, and the reserved encoding behaves the same
                    count_d = next_s;
                    ovf_d   = flow_s & ~dir;
                    unf_d   = flow_s & dir;
                end
            endcase
        end else begin
            count_d = count_q;
        end
    end

    // Count, pulse and FSM state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            state_q <= ST_RUN;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef COUNTER_STICKY_FLAGS_EN
    logic sticky_ovf_q;
    logic sticky_unf_q;

    // Sticky flags survive load; only clear or reset drops them
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else if (clear) begin
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            sticky_ovf_q <= sticky_ovf_q | ovf_d;
            sticky_unf_q <= sticky_unf_q | unf_d;
        end
    end

    assign sticky_ovf = sticky_ovf_q;
    assign sticky_unf = sticky_unf_q;
`else
    assign sticky_ovf = 1'b0;
    assign sticky_unf = 1'b0;
`endif

    assign count_val = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign done      = (state_q == ST_HALT);
    assign match     = (count_q == limit);

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (WIDTH=8, STEP_W=4).
module tb_updown_counter;

`ifdef COUNTER_STICKY_FLAGS_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       en;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       dir;
    logic [3:0] step;
    logic [1:0] mode;
    logic [7:0] limit;
    logic [7:0] count_val;
    logic       overflow;
    logic       underflow;
    logic       match;
    logic       done;
    logic       sticky_ovf;
    logic       sticky_unf;

    int n_checks = 0;
    int n_fails  = 0;

    updown_counter #(.WIDTH(8), .STEP_W(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .dir        (dir),
        .step       (step),
        .mode       (mode),
        .limit      (limit),
        .count_val  (count_val),
        .overflow   (overflow),
        .underflow  (underflow),
        .match      (match),
        .done       (done),
        .sticky_ovf (sticky_ovf),
        .sticky_unf (sticky_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0; load_val = 8'd0;
        dir = 1'b0; step = 4'd0; mode = 2'b00; limit = 8'd5;
        #3;
        chk("rst_count", count_val, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_done", done, 0);
        chk("rst_match_lim5", match, 0);
        chk("rst_sticky", {sticky_ovf, sticky_unf}, 0);
        limit = 8'd0;
        #1;
        chk("rst_match_lim0", match, 1);
        @(negedge clk);
        rstn = 1'b1;
        limit = 8'd200;

        // wrap overflow
        load = 1'b1; load_val = 8'd250;
        tick();
        chk("wrap_load", count_val, 250);
        load = 1'b0; en = 1'b1; step = 4'd4;
        tick();
        chk("wrap_254", count_val, 254);
        chk("wrap_254_ovf", overflow, 0);
        tick();
        chk("wrap_2", count_val, 2);
        chk("wrap_2_ovf", overflow, 1);
        chk("wrap_sticky_set", sticky_ovf, STICKY);
        en = 1'b0;
        tick();
        chk("wrap_hold", count_val, 2);
        chk("wrap_ovf_fall", overflow, 0);
        load = 1'b1; load_val = 8'd100;
        tick();
        chk("sticky_load_cnt", count_val, 100);
        chk("sticky_thru_load", sticky_ovf, STICKY);
        load = 1'b0; clear = 1'b1;
        tick();
        chk("sticky_clear", sticky_ovf, 0);
        clear = 1'b0;

        // saturate down and up
        mode = 2'b01; load = 1'b1; load_val = 8'd3;
        tick();
        load = 1'b0; en = 1'b1; dir = 1'b1; step = 4'd5;
        tick();
        chk("sat_dn_0", count_val, 0);
        chk("sat_dn_unf1", underflow, 1);
        tick();
        chk("sat_dn_0b", count_val, 0);
        chk("sat_dn_unf2", underflow, 1);
        chk("sat_sticky_unf", sticky_unf, STICKY);
        en = 1'b0;
        tick();
        chk("sat_unf_fall", underflow, 0);
        load = 1'b1; load_val = 8'd250;
        tick();
        load = 1'b0; en = 1'b1; dir = 1'b0; step = 4'd15;
        tick();
        chk("sat_up_255", count_val, 255);
        chk("sat_up_ovf", overflow, 1);
        en = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;

        // one-shot up
        mode = 2'b10; limit = 8'd10; step = 4'd3; en = 1'b1;
        tick();
        chk("os_3", count_val, 3);
        tick();
        chk("os_6", count_val, 6);
        tick();
        chk("os_9", count_val, 9);
        chk("os_9_done", done, 0);
        tick();
        chk("os_10", count_val, 10);
        chk("os_10_done", done, 1);
        chk("os_10_match", match, 1);
        chk("os_no_ovf", overflow, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("os_hold", {count_val, done}, {8'd10, 1'b1});
        end
        mode = 2'b00;
        tick();
        chk("os_mode_chg", {count_val, done}, {8'd10, 1'b1});
        mode = 2'b10; en = 1'b0; load = 1'b1; load_val = 8'd0;
        tick();
        chk("os_load_cnt", count_val, 0);
        chk("os_load_done", done, 0);

        // one-shot down overshooting the limit, then start at limit
        load_val = 8'd20;
        tick();
        load = 1'b0; en = 1'b1; dir = 1'b1; step = 4'd4;
        tick();
        chk("osd_16", count_val, 16);
        tick();
        chk("osd_12", count_val, 12);
        tick();
        chk("osd_10", {count_val, done}, {8'd10, 1'b1});
        en = 1'b0; load = 1'b1; load_val = 8'd10;
        tick();
        chk("osl_load", done, 0);
        load = 1'b0; en = 1'b1; dir = 1'b0; step = 4'd1;
        tick();
        chk("osl_halt", {count_val, done}, {8'd10, 1'b1});
        en = 1'b0; mode = 2'b00; clear = 1'b1;
        tick();
        clear = 1'b0;

        // priority clear > load > en, then step 0
        load = 1'b1; load_val = 8'd40;
        tick();
        chk("prio_40", count_val, 40);
        clear = 1'b1; load_val = 8'd77; en = 1'b1; step = 4'd4;
        tick();
        chk("prio_cnt", count_val, 0);
        chk("prio_pulses", {overflow, underflow}, 0);
        clear = 1'b0; load_val = 8'd50;
        tick();
        chk("step0_load", count_val, 50);
        load = 1'b0; step = 4'd0;
        tick();
        chk("step0_hold", count_val, 50);

        // asynchronous reset mid-count
        load = 1'b1; load_val = 8'd123; en = 1'b0;
        tick();
        chk("arst_123", count_val, 123);
        load = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_cnt", count_val, 0);
        chk("arst_flags", {overflow, underflow, done, sticky_ovf, sticky_unf}, 0);
        #1;
        rstn = 1'b1; en = 1'b1; step = 4'd1; dir = 1'b0;
        tick();
        chk("arst_resume1", count_val, 1);
        tick();
        chk("arst_resume2", count_val, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised successor to the generic up counter, used by the core wherever a programmable event/cycle counter is needed (timers, performance counters, delay loops). Counts up or down by a run-time step and supports synchronous load, a compare limit, and three overflow policies: wrap, saturate, and one-shot stop-at-limit. An optional sticky status feature is selected at compile time.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- STEP_W, 4, width of the run-time step input (1..WIDTH)

- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- en  in  1  count enable; one step per cycle while high
- clear  in  1  synchronous clear
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value taken on load
- dir  in  1  0 = count up, 1 = count down
- step  in  STEP_W  increment/decrement magnitude, zero-extended to WIDTH+1
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as 00)
- limit  in  WIDTH  compare / one-shot terminal value
- count_val  out  WIDTH  current count
- overflow  out  1  one-cycle pulse: up-count exceeded 2^WIDTH-1
- underflow  out  1  one-cycle pulse: down-count went below 0
- match  out  1  level, count_val == limit (combinational compare of registered count)
- done  out  1  level, one-shot reached limit
- sticky_ovf  out  1  sticky overflow (see Configuration)
- sticky_unf  out  1  sticky underflow (see Configuration)

## Operation
- Priority each cycle: rstn > clear > load > en.
- clear: count_val=0, overflow=underflow=0, sticky flags=0, state→RUN.
- load: count_val=load_val, pulses=0, state→RUN; sticky flags unchanged.
- Arithmetic in WIDTH+1 bits: up sum = count_val + step; carry bit = overflow condition. Down: underflow condition = step > count_val; result = count_val − step mod 2^WIDTH.
- step == 0: count unchanged, no pulses, done unaffected.
- FSM states RUN, HALT (reset state RUN).
- RUN, mode wrap: count_val = result mod 2^WIDTH; overflow/underflow pulse on the carry/borrow cycle.
- RUN, mode saturate: on carry count_val = all ones; on borrow count_val = 0; pulse asserted on every clamping cycle, including when already at the bound.
- RUN, mode one-shot: if up and next ≥ limit, or down and next ≤ limit, or carry/borrow occurs: count_val = limit, state→HALT. No overflow/underflow pulse in one-shot mode.
- HALT: en ignored, count_val held, done=1. Exit only via clear, load, or reset. Mode changes in HALT have no effect.
- One-shot started with count_val already equal to limit: first enabled cycle with step ≠ 0 enters HALT, count stays limit.
- dir, step, mode, limit sampled every cycle; changing them mid-count takes effect on the next enabled cycle.

## Timing
- Reset (asynchronous, immediate): count_val=0, overflow=0, underflow=0, done=0, sticky_ovf=0, sticky_unf=0, state RUN; match reflects 0 == limit.
- Latency: count_val, pulses, done valid one clock after the enabling edge. match follows count_val combinationally, same cycle.
- Pulses last exactly one cycle unless the condition repeats on the next enabled cycle.
- done rises in the same cycle count_val becomes limit; falls the cycle after clear/load.

## Configuration
- COUNTER_STICKY_FLAGS_EN defined: sticky_ovf/sticky_unf set on any overflow/underflow pulse, hold until clear or reset (not load).
- Undefined: no sticky registers; sticky_ovf and sticky_unf tied to 0.

## Test plan
- WIDTH=8, STEP_W=4, mode 00, load 250, dir 0, step 4, en 2 cycles → 254, then 2 with overflow=1 for exactly one cycle.
- mode 01, load 3, dir 1, step 5, en 2 cycles → 0 with underflow pulse each cycle; count stays 0.
- mode 10, clear, limit 10, step 3, en held → 3, 6, 9, 10; done=1 at 10; 5 further en cycles hold 10 and done; load 0 drops done next cycle.
- clear, load (load_val 77) and en all high in one cycle at count 40 → count 0, all pulses 0.
- Assert rstn=0 mid-count at 123 between clock edges → outputs go to reset values immediately; counting resumes from 0 after release.
- With COUNTER_STICKY_FLAGS_EN: wrap overflow → sticky_ovf stays 1 through load, clears on clear; without macro sticky_ovf stays 0.
